// File: rtl/mct_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mct_scheduler
// Purpose  : Run/stop and single-step controller for the time-pulse ring.
//            Generates one-hot TP1..TPn pulses and picks the memory-cycle
//            type (IDLE/INST/CTR/INTR) at the start of every MCT.
// Ports    : clk, rst_n (sync, active-low)
//            run          - level, free-run consecutive MCTs
//            step         - single-MCT request (rising edge detected here)
//            ctr_req      - counter-increment request pulses
//            intr_req     - interrupt request level
//            intr_inhibit - 1 masks interrupts
//            tp           - one-hot time pulses, tp[0] = TP1
//            cycle_type   - 00 IDLE, 01 INST, 10 CTR, 11 INTR
//            ctr_grant    - one-hot counter serviced by the current CTR MCT
//            intr_ack     - one-clock pulse on TP1 of an INTR MCT
//            running      - 1 while any tp bit is high
//            mct_count    - count of MCTs started (wraps)
//            stall        - only with MCT_STALL_EN: hold at TPn while high
// Options  : `define MCT_STALL_EN adds the stall input (slow-memory wait).
// Revision : 1.0 - initial release
// ============================================================================
module mct_scheduler #(
    parameter int NUM_TP    = 9,
    parameter int NUM_CTR   = 4,
    parameter int MAX_BURST = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step,
    input  logic [NUM_CTR-1:0] ctr_req,
    input  logic               intr_req,
    input  logic               intr_inhibit,
    output logic [NUM_TP-1:0]  tp,
    output logic [1:0]         cycle_type,
    output logic [NUM_CTR-1:0] ctr_grant,
    output logic               intr_ack,
    output logic               running,
    output logic [15:0]        mct_count
`ifdef MCT_STALL_EN
    ,
    input  logic               stall
`endif
);

    localparam int C_BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] C_CT_IDLE = 2'b00;
    localparam logic [1:0] C_CT_INST = 2'b01;
    localparam logic [1:0] C_CT_CTR  = 2'b10;
    localparam logic [1:0] C_CT_INTR = 2'b11;

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_ACTIVE  = 1'b1
    } state_t;

    state_t             r_state_q,      w_state_d;
    logic [NUM_TP-1:0]  r_tp_q,         w_tp_d;
    logic [1:0]         r_ctype_q,      w_ctype_d;
    logic [NUM_CTR-1:0] r_grant_q,      w_grant_d;
    logic               r_ack_q,        w_ack_d;
    logic               r_running_q,    w_running_d;
    logic [15:0]        r_count_q,      w_count_d;
    logic [NUM_CTR-1:0] r_pend_q,       w_pend_d;
    logic [C_BW-1:0]    r_burst_q,      w_burst_d;
    logic               r_step_q,       w_step_d;
    logic               r_lock_q,       w_lock_d;

    logic               w_stall;
    logic               w_step_edge;
    logic               w_last;
    logic               w_start;
    logic               w_stop;
    logic               w_ctr_ok;
    logic               w_intr_ok;
    logic [NUM_CTR-1:0] w_lowest;
    logic [NUM_CTR-1:0] w_clr;

`ifdef MCT_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_step_edge = step & ~r_step_q;
        w_last      = r_tp_q[NUM_TP-1];

        // The run/stop decision at TPn is deferred while the MCT is stalled.
        if (r_state_q == ST_STOPPED) begin
            w_start = run | w_step_edge;
            w_stop  = 1'b0;
        end else begin
            w_start = w_last & ~w_stall & run;
            w_stop  = w_last & ~w_stall & ~run;
        end

        // Isolate the lowest set pending bit (two's-complement trick).
        w_lowest  = r_pend_q & (~r_pend_q + NUM_CTR'(1));
        w_ctr_ok  = (|r_pend_q) && (r_burst_q != C_BW'(MAX_BURST));
        w_intr_ok = intr_req & ~intr_inhibit & ~r_lock_q;

        w_state_d = r_state_q;
        w_tp_d    = r_tp_q;
        w_ctype_d = r_ctype_q;
        w_grant_d = r_grant_q;
        w_ack_d   = 1'b0;
        w_count_d = r_count_q;
        w_burst_d = r_burst_q;
        w_lock_d  = r_lock_q;
        w_clr     = '0;
        w_step_d  = step;

        if (w_start) begin
            w_state_d = ST_ACTIVE;
            w_tp_d    = NUM_TP'(1);
            w_count_d = r_count_q + 16'd1;
            if (w_ctr_ok) begin
                w_ctype_d = C_CT_CTR;
                w_grant_d = w_lowest;
                w_clr     = w_lowest;
                w_burst_d = r_burst_q + C_BW'(1);
            end else if (w_intr_ok) begin
                w_ctype_d = C_CT_INTR;
                w_grant_d = '0;
                w_ack_d   = 1'b1;
                w_lock_d  = 1'b1;
                w_burst_d = '0;
            end else begin
                w_ctype_d = C_CT_INST;
                w_grant_d = '0;
                w_lock_d  = 1'b0;
                w_burst_d = '0;
            end
        end else if (w_stop) begin
            w_state_d = ST_STOPPED;
            w_tp_d    = '0;
            w_ctype_d = C_CT_IDLE;
            w_grant_d = '0;
        end else if ((r_state_q == ST_ACTIVE) && !w_last) begin
            w_tp_d = {r_tp_q[NUM_TP-2:0], 1'b0};
        end

        // A new request on the granting edge wins over the clear.
        w_pend_d    = (r_pend_q & ~w_clr) | ctr_req;
        w_running_d = |w_tp_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q   <= ST_STOPPED;
            r_tp_q      <= '0;
            r_ctype_q   <= C_CT_IDLE;
            r_grant_q   <= '0;
            r_ack_q     <= 1'b0;
            r_running_q <= 1'b0;
            r_count_q   <= '0;
            r_pend_q    <= '0;
            r_burst_q   <= '0;
            r_step_q    <= 1'b0;
            r_lock_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_tp_q      <= w_tp_d;
            r_ctype_q   <= w_ctype_d;
            r_grant_q   <= w_grant_d;
            r_ack_q     <= w_ack_d;
            r_running_q <= w_running_d;
            r_count_q   <= w_count_d;
            r_pend_q    <= w_pend_d;
            r_burst_q   <= w_burst_d;
            r_step_q    <= w_step_d;
            r_lock_q    <= w_lock_d;
        end
    end

    assign tp         = r_tp_q;
    assign cycle_type = r_ctype_q;
    assign ctr_grant  = r_grant_q;
    assign intr_ack   = r_ack_q;
    assign running    = r_running_q;
    assign mct_count  = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mct_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mct_scheduler
// Purpose  : Directed self-checking bench for mct_scheduler with
//            hand-computed expectations (default parameters 9/4/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mct_scheduler;

    localparam int NUM_TP  = 9;
    localparam int NUM_CTR = 4;

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_INST = 2'b01;
    localparam logic [1:0] C_CTR  = 2'b10;
    localparam logic [1:0] C_INTR = 2'b11;

    logic               clk;
    logic               rst_n;
    logic               run;
    logic               step;
    logic [NUM_CTR-1:0] ctr_req;
    logic               intr_req;
    logic               intr_inhibit;
    logic [NUM_TP-1:0]  tp;
    logic [1:0]         cycle_type;
    logic [NUM_CTR-1:0] ctr_grant;
    logic               intr_ack;
    logic               running;
    logic [15:0]        mct_count;

    int n_checks;
    int n_fail;
    int exp_cnt;

    mct_scheduler #(
        .NUM_TP    (9),
        .NUM_CTR   (4),
        .MAX_BURST (3)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .step         (step),
        .ctr_req      (ctr_req),
        .intr_req     (intr_req),
        .intr_inhibit (intr_inhibit),
        .tp           (tp),
        .cycle_type   (cycle_type),
        .ctr_grant    (ctr_grant),
        .intr_ack     (intr_ack),
        .running      (running),
        .mct_count    (mct_count)
`ifdef MCT_STALL_EN
        ,
        .stall        (1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next TP1 and check the MCT that starts there.
    task automatic next_mct(input string tag, input logic [1:0] ct, input logic [NUM_CTR-1:0] gnt,
                            input logic ack);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tp != 9'd1 && n < 2 * NUM_TP + 2);
        if (tp != 9'd1) begin
            check({tag, "_timeout"}, 32'(tp), 32'd1);
        end else begin
            exp_cnt++;
            check({tag, "_type"},  32'(cycle_type), 32'(ct));
            check({tag, "_grant"}, 32'(ctr_grant),  32'(gnt));
            check({tag, "_ack"},   32'(intr_ack),   32'(ack));
            check({tag, "_count"}, 32'(mct_count),  32'(exp_cnt));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tp"},      32'(tp),         32'd0);
        check({tag, "_type"},    32'(cycle_type), 32'(C_IDLE));
        check({tag, "_grant"},   32'(ctr_grant),  32'd0);
        check({tag, "_ack"},     32'(intr_ack),   32'd0);
        check({tag, "_running"}, 32'(running),    32'd0);
        check({tag, "_count"},   32'(mct_count),  32'd0);
    endtask

    initial begin
        logic [1:0] burst_exp [8];
        burst_exp = '{C_CTR, C_CTR, C_CTR, C_INST, C_CTR, C_CTR, C_CTR, C_INST};

        n_checks     = 0;
        n_fail       = 0;
        exp_cnt      = 0;
        rst_n        = 1'b0;
        run          = 1'b0;
        step         = 1'b0;
        ctr_req      = '0;
        intr_req     = 1'b0;
        intr_inhibit = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");

        // Free run: TP1 one cycle after run, full ring, no gap.
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        exp_cnt = 1;
        check("run_tp1",     32'(tp),         32'd1);
        check("run_type",    32'(cycle_type), 32'(C_INST));
        check("run_count1",  32'(mct_count),  32'd1);
        check("run_running", 32'(running),    32'd1);
        for (int k = 1; k < NUM_TP; k++) begin
            @(negedge clk);
            check($sformatf("run_tp%0d", k + 1), 32'(tp), 32'd1 << k);
        end
        @(negedge clk);
        exp_cnt = 2;
        check("run_nogap", 32'(tp),        32'd1);
        check("run_count2", 32'(mct_count), 32'd2);

        // run dropped at TP1: MCT completes through TP9, then stops.
        run = 1'b0;
        for (int k = 1; k < NUM_TP; k++) begin
            @(negedge clk);
            check($sformatf("drop_tp%0d", k + 1), 32'(tp), 32'd1 << k);
        end
        @(negedge clk);
        check("drop_tp",      32'(tp),         32'd0);
        check("drop_running", 32'(running),    32'd0);
        check("drop_type",    32'(cycle_type), 32'(C_IDLE));

        // Single step; a second edge mid-MCT is ignored.
        step = 1'b1;
        @(negedge clk);
        exp_cnt = 3;
        check("step_tp1",   32'(tp),        32'd1);
        check("step_count", 32'(mct_count), 32'd3);
        step = 1'b0;
        for (int k = 1; k < NUM_TP; k++) begin
            @(negedge clk);
            if (k == 3) step = 1'b1;
            if (k == 5) step = 1'b0;
            check($sformatf("step_tp%0d", k + 1), 32'(tp), 32'd1 << k);
        end
        @(negedge clk);
        check("step_end_tp",      32'(tp),      32'd0);
        check("step_end_running", 32'(running), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("step_noextra_tp",    32'(tp),        32'd0);
        check("step_noextra_count", 32'(mct_count), 32'd3);

        // Two counter requests together: lowest index first, then INST.
        run = 1'b1;
        next_mct("ctr_pre", C_INST, 4'b0000, 1'b0);
        @(negedge clk);
        ctr_req = 4'b1010;
        @(negedge clk);
        ctr_req = 4'b0000;
        next_mct("ctr_a", C_CTR, 4'b0010, 1'b0);
        repeat (4) @(negedge clk);
        check("ctr_a_hold_type",  32'(cycle_type), 32'(C_CTR));
        check("ctr_a_hold_grant", 32'(ctr_grant),  32'h2);
        next_mct("ctr_b", C_CTR,  4'b1000, 1'b0);
        next_mct("ctr_c", C_INST, 4'b0000, 1'b0);
        next_mct("ctr_d", C_INST, 4'b0000, 1'b0);

        // ctr_req[0] every MCT: CTR,CTR,CTR,INST repeating.
        for (int m = 0; m < 8; m++) begin
            ctr_req = 4'b0001;
            @(negedge clk);
            ctr_req = 4'b0000;
            next_mct($sformatf("burst%0d", m), burst_exp[m],
                     (burst_exp[m] == C_CTR) ? 4'b0001 : 4'b0000, 1'b0);
        end
        next_mct("burst_drain", C_CTR,  4'b0001, 1'b0);
        next_mct("burst_idle",  C_INST, 4'b0000, 1'b0);

        // Interrupts: INTR, INST, INTR while held; then masked.
        intr_req = 1'b1;
        next_mct("intr_a", C_INTR, 4'b0000, 1'b1);
        @(negedge clk);
        check("intr_a_ack_tp2", 32'(intr_ack), 32'd0);
        next_mct("intr_b", C_INST, 4'b0000, 1'b0);
        next_mct("intr_c", C_INTR, 4'b0000, 1'b1);
        intr_inhibit = 1'b1;
        next_mct("inh_a", C_INST, 4'b0000, 1'b0);
        next_mct("inh_b", C_INST, 4'b0000, 1'b0);
        intr_req     = 1'b0;
        intr_inhibit = 1'b0;

        // Reset at TP5 of a CTR MCT with another counter still pending.
        ctr_req = 4'b0100;
        @(negedge clk);
        ctr_req = 4'b0000;
        next_mct("rst_ctr", C_CTR, 4'b0100, 1'b0);
        ctr_req = 4'b0001;
        @(negedge clk);
        ctr_req = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_at_tp5", 32'(tp), 32'h10);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_tp1",   32'(tp),         32'd1);
        check("after_rst_type",  32'(cycle_type), 32'(C_INST));
        check("after_rst_grant", 32'(ctr_grant),  32'd0);
        check("after_rst_count", 32'(mct_count),  32'd1);

        run = 1'b0;
        repeat (NUM_TP + 2) @(negedge clk);
        check("final_stopped", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
